// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_pkg;

  localparam int unsigned UART_STATE_W  = 3;
  localparam int unsigned UART_DIV_W    = 16;
  localparam int unsigned UART_BITS_W   = 2;
  localparam int unsigned UART_NBITS_W  = 4;
  localparam logic        UART_IDLE_LVL = 1'b1;
  localparam int unsigned UART_MIN_DIV  = 8;

  typedef enum logic [UART_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } uart_state_e;

  // Data-bit count encoding: 00=5 .. 11=8
  function automatic logic [UART_NBITS_W-1:0] cfg_bits_to_n(input logic [UART_BITS_W-1:0] bits);
    return UART_NBITS_W'(bits) + UART_NBITS_W'(5);
  endfunction

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Bit-period counter for the receiver: counts 0..div-1 and wraps.
// Tick outputs are registered and describe the count held in the current cycle.
module uart_rx_baud_cnt
  import uart_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [UART_DIV_W-1:0] cfg_div_i,
  output logic                  tick_half_o,
  output logic                  tick_full_o
);

  logic [UART_DIV_W-1:0] div_eff;
  logic [UART_DIV_W-1:0] half_m1;
  logic [UART_DIV_W-1:0] cnt_q, cnt_d;
  logic                  tick_half_q, tick_full_q;

  // Illegal small divisors are clamped so the mid-bit point never underflows
  assign div_eff = (cfg_div_i < UART_DIV_W'(UART_MIN_DIV)) ? UART_DIV_W'(UART_MIN_DIV) : cfg_div_i;
  assign half_m1 = (div_eff >> 1) - UART_DIV_W'(1);

  // Next count: clear wins, otherwise advance and wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == div_eff - UART_DIV_W'(1)) ? '0 : cnt_q + UART_DIV_W'(1);
    end
  end

  // Counter and tick registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q       <= '0;
      tick_half_q <= 1'b0;
      tick_full_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tick_half_q <= (cnt_d == half_m1);
      tick_full_q <= (cnt_d == div_eff - UART_DIV_W'(1));
    end
  end

  assign tick_half_o = tick_half_q;
  assign tick_full_o = tick_full_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchroniser, frame FSM, shift register, even-parity check,
// valid/ready output register with overrun detection.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around
// each sample point (one cycle of extra decision latency).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   rx_i,
  output logic                   busy_o,
  input  logic                   cfg_en_i,
  input  logic [UART_DIV_W-1:0]  cfg_div_i,
  input  logic                   cfg_parity_en_i,
  input  logic [UART_BITS_W-1:0] cfg_bits_i,
  input  logic                   cfg_stop_bits_i,
  output logic [DATA_WIDTH-1:0]  rx_data_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic                   err_parity_o,
  output logic                   err_frame_o,
  output logic                   err_overrun_o
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH + 1);

  uart_state_e              state_q, state_d;
  logic                     sync1_q, sync2_q, rx_prev_q;
  logic                     rx_s, rx_fall;
  logic                     tick_half, tick_full, baud_clear;
  logic                     samp_val, start_stb, deliver;
  logic [UART_NBITS_W-1:0]  n_bits;
  logic [SHAMT_W-1:0]       shamt;
  logic [UART_NBITS_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic                     par_q, par_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0]    rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     err_par_q, err_par_d, err_frm_q, err_frm_d, err_ovr_q, err_ovr_d;

  assign rx_s    = sync2_q;
  assign rx_fall = rx_prev_q & ~rx_s;
  assign n_bits  = cfg_bits_to_n(cfg_bits_i);
  assign shamt   = SHAMT_W'(DATA_WIDTH) - SHAMT_W'(n_bits);

  uart_rx_baud_cnt u_baud (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clear_i     (baud_clear),
    .en_i        (1'b1),
    .cfg_div_i   (cfg_div_i),
    .tick_half_o (tick_half),
    .tick_full_o (tick_full)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  logic       half_dly_q;

  // Two previous line samples plus the delayed mid-bit strobe for the vote
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hist_q     <= {2{UART_IDLE_LVL}};
      half_dly_q <= 1'b0;
    end else begin
      hist_q     <= {hist_q[0], rx_s};
      half_dly_q <= tick_half;
    end
  end

  assign samp_val  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
  assign start_stb = half_dly_q;
`else
  assign samp_val  = rx_s;
  assign start_stb = tick_half;
`endif

  // Line synchroniser and edge-detect history
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q   <= UART_IDLE_LVL;
      sync2_q   <= UART_IDLE_LVL;
      rx_prev_q <= UART_IDLE_LVL;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; disabling the receiver aborts any frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cfg_en_i && rx_fall) state_d = ST_START;
      ST_START:  if (start_stb) state_d = samp_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick_full && (bit_cnt_q == n_bits - UART_NBITS_W'(1)))
                   state_d = cfg_parity_en_i ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (tick_full) state_d = ST_STOP1;
      ST_STOP1:  if (tick_full) state_d = cfg_stop_bits_i ? ST_STOP2 : ST_IDLE;
      ST_STOP2:  if (tick_full) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (!cfg_en_i) state_d = ST_IDLE;
  end

  // Datapath and output next values for each state
  always_comb begin
    baud_clear = 1'b0;
    deliver    = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    err_par_d  = 1'b0;
    err_frm_d  = 1'b0;
    err_ovr_d  = 1'b0;

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_clear = 1'b1;
        bit_cnt_d  = '0;
        shift_d    = '0;
        par_d      = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
      end
      ST_START:  if (start_stb) baud_clear = 1'b1;
      ST_DATA: if (tick_full) begin
        shift_d   = {samp_val, shift_q[DATA_WIDTH-1:1]};
        par_d     = par_q ^ samp_val;
        bit_cnt_d = bit_cnt_q + UART_NBITS_W'(1);
      end
      ST_PARITY: if (tick_full) perr_d = par_q ^ samp_val;
      ST_STOP1: if (tick_full) begin
        ferr_d  = ferr_q | ~samp_val;
        deliver = ~cfg_stop_bits_i;
      end
      ST_STOP2: if (tick_full) begin
        ferr_d  = ferr_q | ~samp_val;
        deliver = 1'b1;
      end
      default: ;
    endcase

    // A frame still unread blocks the new one unless it is taken this cycle
    if (deliver && cfg_en_i) begin
      err_par_d = perr_q;
      err_frm_d = ferr_d;
      if (rx_valid_q && !rx_ready_i) begin
        err_ovr_d = 1'b1;
      end else begin
        rx_data_d  = shift_q >> shamt;
        rx_valid_d = 1'b1;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign err_parity_o  = err_par_q;
  assign err_frame_o   = err_frm_q;
  assign err_overrun_o = err_ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial transmitter model, delivery monitor and frame
// expectations derived from the frame format. Honours UART_RX_MAJORITY_EN.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx;
  logic        busy;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic        cfg_par;
  logic [1:0]  cfg_bits;
  logic        cfg_stop;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        err_par, err_frm, err_ovr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ovr_cnt = 0;
  int start_cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } rx_ev_t;

  rx_ev_t evq[$];
  rx_ev_t mon_ev;
  logic   v_prev = 1'b0;
  logic   r_prev = 1'b0;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .rx_i            (rx),
    .busy_o          (busy),
    .cfg_en_i        (cfg_en),
    .cfg_div_i       (cfg_div),
    .cfg_parity_en_i (cfg_par),
    .cfg_bits_i      (cfg_bits),
    .cfg_stop_bits_i (cfg_stop),
    .rx_data_o       (rx_data),
    .rx_valid_o      (rx_valid),
    .rx_ready_i      (rx_ready),
    .err_parity_o    (err_par),
    .err_frame_o     (err_frm),
    .err_overrun_o   (err_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every newly presented byte and every overrun pulse
  always @(negedge clk) begin
    if (!rstn) begin
      v_prev = 1'b0;
      r_prev = 1'b0;
    end else begin
      if (rx_valid && (!v_prev || r_prev)) begin
        mon_ev.data = rx_data;
        mon_ev.perr = err_par;
        mon_ev.ferr = err_frm;
        mon_ev.cyc  = cyc;
        evq.push_back(mon_ev);
      end
      if (err_ovr) ovr_cnt++;
      v_prev = rx_valid;
      r_prev = rx_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int div, input int bits, input bit par, input bit stop2);
    cfg_div  = 16'(div);
    cfg_bits = 2'(bits);
    cfg_par  = par;
    cfg_stop = stop2;
  endtask

  // One bit period on the line, optionally inverted for a single mid-bit cycle
  task automatic drive_bit(input logic v, input bit glitch);
    for (int j = 0; j < int'(cfg_div); j++) begin
      rx = (glitch && j == int'(cfg_div) / 2) ? ~v : v;
      tick(1);
    end
  endtask

  // Transmitter model using the current cfg_* settings
  task automatic send_frame(input logic [7:0] data, input bit par_bad, input bit stop0, input int glitch_bit);
    int         nb;
    logic [7:0] m;
    nb = int'(cfg_bits) + 5;
    m  = data & 8'((1 << nb) - 1);
    start_cyc = cyc;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(m[i], i == glitch_bit);
    if (cfg_par) drive_bit((^m) ^ par_bad, 1'b0);
    drive_bit(~stop0, 1'b0);
    if (cfg_stop) drive_bit(1'b1, 1'b0);
    rx = 1'b1;
  endtask

  task automatic get_ev(output rx_ev_t ev, output bit ok);
    int n = 0;
    while (evq.size() == 0 && n < 400) begin
      tick(1);
      n++;
    end
    ok = (evq.size() != 0);
    if (ok) ev = evq.pop_front();
    else begin
      ev.data = 'x;
      ev.perr = 'x;
      ev.ferr = 'x;
      ev.cyc  = 0;
    end
  endtask

  // Expected byte: data bits beyond the frame length are zero; errors follow injected faults
  task automatic check_frame(input string tag, input logic [7:0] data, input bit par_bad,
                             input bit stop0, output rx_ev_t ev);
    bit         ok;
    logic [7:0] exp_data;
    exp_data = data & 8'((1 << (int'(cfg_bits) + 5)) - 1);
    get_ev(ev, ok);
    check({tag, "_delivered"}, 32'(ok), 32'd1);
    check({tag, "_data"}, 32'(ev.data), 32'(exp_data));
    check({tag, "_perr"}, 32'(ev.perr), 32'(cfg_par & par_bad));
    check({tag, "_ferr"}, 32'(ev.ferr), 32'(stop0));
  endtask

  rx_ev_t     ev;
  logic [7:0] rd;
  int         rdiv;

  initial begin
    rstn     = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    cfg_en   = 1'b1;
    set_cfg(16, 3, 1'b0, 1'b0);
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_errs", 32'({err_par, err_frm, err_ovr}), 32'd0);
    rstn = 1'b1;
    tick(20);

    // Basic 8N1 byte and its latency from the start edge
    send_frame(8'hA5, 1'b0, 1'b0, -1);
    check_frame("t1", 8'hA5, 1'b0, 1'b0, ev);
    check("t1_latency_ok", 32'((ev.cyc - start_cyc) <= 164), 32'd1);
    tick(2);
    check("t1_valid_pulse", 32'(rx_valid), 32'd0);
    tick(16);

    // 8E2: wrong parity then correct parity
    set_cfg(16, 3, 1'b1, 1'b1);
    tick(4);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    check_frame("t2a", 8'h3C, 1'b1, 1'b0, ev);
    tick(16);
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    check_frame("t2b", 8'h3C, 1'b0, 1'b0, ev);
    tick(16);

    // 5N1 framing error, line held low, then recovery
    set_cfg(16, 0, 1'b0, 1'b0);
    tick(4);
    send_frame(8'h15, 1'b0, 1'b1, -1);
    rx = 1'b0;
    check_frame("t3a", 8'h15, 1'b0, 1'b1, ev);
    tick(20 * 16);
    check("t3_no_frame_low", 32'(evq.size()), 32'd0);
    check("t3_idle_low", 32'(busy), 32'd0);
    rx = 1'b1;
    tick(32);
    send_frame(8'h0A, 1'b0, 1'b0, -1);
    check_frame("t3b", 8'h0A, 1'b0, 1'b0, ev);
    tick(16);

    // Overrun while the consumer is stalled
    set_cfg(16, 3, 1'b0, 1'b0);
    rx_ready = 1'b0;
    tick(4);
    send_frame(8'h11, 1'b0, 1'b0, -1);
    tick(16);
    send_frame(8'h22, 1'b0, 1'b0, -1);
    tick(16);
    check_frame("t4", 8'h11, 1'b0, 1'b0, ev);
    check("t4_hold_data", 32'(rx_data), 32'h11);
    check("t4_hold_valid", 32'(rx_valid), 32'd1);
    check("t4_overruns", 32'(ovr_cnt), 32'd1);
    rx_ready = 1'b1;
    tick(1);
    check("t4_valid_clear", 32'(rx_valid), 32'd0);
    tick(16);

    // False start, enable drop mid-frame, asynchronous reset mid-frame
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    check("t5_busy_start", 32'(busy), 32'd1);
    tick(40);
    check("t5_false_idle", 32'(busy), 32'd0);
    check("t5_false_noframe", 32'(evq.size()), 32'd0);
    rx = 1'b0;
    tick(16);
    rx = 1'b1;
    tick(20);
    check("t5_busy_data", 32'(busy), 32'd1);
    cfg_en = 1'b0;
    tick(1);
    check("t5_en_drop_idle", 32'(busy), 32'd0);
    tick(160);
    cfg_en = 1'b1;
    tick(4);
    check("t5_en_drop_noframe", 32'(evq.size()), 32'd0);
    check("t5_en_drop_valid", 32'(rx_valid), 32'd0);
    rx = 1'b0;
    tick(30);
    rstn = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_data", 32'(rx_data), 32'd0);
    rx = 1'b1;
    tick(3);
    rstn = 1'b1;
    tick(20);

    // Single-cycle glitch at the centre of data bit 3
    send_frame(8'h00, 1'b0, 1'b0, 3);
    get_ev(ev, rd[0]);
    check("t6_delivered", 32'(rd[0]), 32'd1);
`ifdef UART_RX_MAJORITY_EN
    check("t6_glitch_data", 32'(ev.data), 32'h00);
`else
    check("t6_glitch_data", 32'(ev.data), 32'h08);
`endif
    tick(16);

    // Randomised formats, divisors, data and injected faults
    for (int k = 0; k < 16; k++) begin
      rdiv = int'($urandom_range(8, 20));
      set_cfg(rdiv, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick(2 * rdiv);
      rd = 8'($urandom);
      begin
        bit pb, s0;
        pb = ($urandom_range(0, 3) == 0);
        s0 = ($urandom_range(0, 4) == 0);
        send_frame(rd, pb, s0, -1);
        check_frame($sformatf("rnd%0d", k), rd, pb, s0, ev);
      end
      tick(rdiv);
    end
    check("end_overruns", 32'(ovr_cnt), 32'd1);
    check("end_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
